// File: rtl/fifo_burst_writer_if.sv
// Command and FIFO push-port bundle for the burst writer.
// Latency: none, wires only.
// Backpressure: push_grant from the FIFO side throttles push_valid/push_data.
interface fifo_burst_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_start;
  logic [DATA_WIDTH-1:0] cmd_stride;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH:0]   push_data;
  logic                  push_valid;
  logic                  push_grant;

  // Writer side: consumes commands, drives the push port.
  modport master (
    input  cmd_valid, cmd_start, cmd_stride, cmd_len, push_grant,
    output cmd_ready, push_data, push_valid
  );

  // Environment side: issues commands, grants pushes.
  modport slave (
    output cmd_valid, cmd_start, cmd_stride, cmd_len, push_grant,
    input  cmd_ready, push_data, push_valid
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// Burst source: turns a (start, stride, len) command into an arithmetic word stream with a last flag.
// Latency: first word valid the cycle after command acceptance; one word per granted cycle.
// Backpressure: without push_grant the current word is held stable and stall_cycles counts up.
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_burst_writer_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] words_sent_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  xfer;

  // A transfer only happens while a word is offered; grant alone is ignored.
  assign xfer = (state_q == SEND) && bus.push_grant;

  // Next-state, datapath and status counter updates.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    words_d     = words_q;
    stall_d     = stall_q;

    if (xfer) begin
      words_d = words_q + CNT_WIDTH'(1);
    end
    if ((state_q == SEND) && !bus.push_grant && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          stride_d    = bus.cmd_stride;
          remaining_d = bus.cmd_len;
          data_d      = {(bus.cmd_len == '0), bus.cmd_start};
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.push_grant) begin
          if (remaining_q != '0) begin
            // Payload wraps modulo 2^DATA_WIDTH; last flag arms on the final word.
            data_d      = {(remaining_q == LEN_WIDTH'(1)),
                           data_q[DATA_WIDTH-1:0] + stride_q};
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end else begin
            data_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      words_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      words_q     <= words_d;
      stall_q     <= stall_d;
    end
  end

  // Every output is decoded from flops only, so valid never depends on grant.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.push_valid = (state_q == SEND);
  assign bus.push_data  = data_q;
  assign busy_o         = (state_q == SEND);
  assign done_o         = done_q;
  assign words_sent_o   = words_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: bursts, stalls, wrap, busy commands, reset, FIFO model.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: push_grant driven directly or from a depth-4 FIFO model.
module tb_fifo_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done;
  logic [15:0] words_sent, stall_cycles;
  int          checks = 0;
  int          errors = 0;

  fifo_burst_writer_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

  fifo_burst_writer #(.DATA_WIDTH(32), .LEN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .words_sent_o   (words_sent),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] start, input logic [31:0] stride, input logic [7:0] len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_start  = start;
    bus.cmd_stride = stride;
    bus.cmd_len    = len;
    step();
    bus.cmd_valid  = 1'b0;
  endtask

  logic [32:0] fifo_q[$];
  logic [32:0] popped[$];
  logic        pop_grant;

  // One cycle of writer feeding a depth-4 FIFO model; grant means not full.
  task automatic fifo_cycle();
    logic        v;
    logic [32:0] d;
    logic        g;
    v = bus.push_valid;
    d = bus.push_data;
    g = (fifo_q.size() < 4);
    bus.push_grant = g;
    step();
    if (pop_grant && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
    if (v && g) fifo_q.push_back(d);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = '0;
    bus.cmd_stride = '0;
    bus.cmd_len    = '0;
    bus.push_grant = 1'b1;
    pop_grant      = 1'b0;

    // Reset state
    step();
    chk("rst_valid", 64'(bus.push_valid), 64'd0);
    chk("rst_data", 64'(bus.push_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_sent), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Basic burst, grant tied high
    send_cmd(32'h10, 32'd4, 8'd3);
    chk("b_w0", 64'(bus.push_data), 64'h0_00000010);
    chk("b_valid", 64'(bus.push_valid), 64'd1);
    chk("b_busy", 64'(busy), 64'd1);
    chk("b_ready", 64'(bus.cmd_ready), 64'd0);
    step(); chk("b_w1", 64'(bus.push_data), 64'h0_00000014);
    step(); chk("b_w2", 64'(bus.push_data), 64'h0_00000018);
    step(); chk("b_w3", 64'(bus.push_data), 64'h1_0000001C);
    step();
    chk("b_done", 64'(done), 64'd1);
    chk("b_valid_end", 64'(bus.push_valid), 64'd0);
    chk("b_data_end", 64'(bus.push_data), 64'd0);
    chk("b_ready_end", 64'(bus.cmd_ready), 64'd1);
    chk("b_words", 64'(words_sent), 64'd4);
    chk("b_stall", 64'(stall_cycles), 64'd0);
    step();
    chk("b_done_pulse", 64'(done), 64'd0);

    // Backpressure on the second word
    send_cmd(32'h10, 32'd4, 8'd3);
    step();
    chk("bp_w1", 64'(bus.push_data), 64'h0_00000014);
    bus.push_grant = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("bp_hold", 64'(bus.push_data), 64'h0_00000014);
      chk("bp_hold_valid", 64'(bus.push_valid), 64'd1);
      chk("bp_stall", 64'(stall_cycles), 64'(i));
    end
    bus.push_grant = 1'b1;
    step(); chk("bp_w2", 64'(bus.push_data), 64'h0_00000018);
    step(); chk("bp_w3", 64'(bus.push_data), 64'h1_0000001C);
    step();
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_words", 64'(words_sent), 64'd8);
    chk("bp_stall_end", 64'(stall_cycles), 64'd3);

    // Payload wrap, then single-word burst
    send_cmd(32'hFFFFFFFE, 32'd1, 8'd2);
    chk("wr_w0", 64'(bus.push_data), 64'h0_FFFFFFFE);
    step(); chk("wr_w1", 64'(bus.push_data), 64'h0_FFFFFFFF);
    step(); chk("wr_w2", 64'(bus.push_data), 64'h1_00000000);
    step(); chk("wr_done", 64'(done), 64'd1);
    send_cmd(32'h5, 32'd7, 8'd0);
    chk("sw_w0", 64'(bus.push_data), 64'h1_00000005);
    step();
    chk("sw_done", 64'(done), 64'd1);
    chk("sw_words", 64'(words_sent), 64'd12);

    // Command offered while busy, held through the done cycle
    send_cmd(32'h100, 32'h10, 8'd2);
    chk("cb_w0", 64'(bus.push_data), 64'h0_00000100);
    bus.cmd_valid  = 1'b1;
    bus.cmd_start  = 32'h200;
    bus.cmd_stride = 32'd2;
    bus.cmd_len    = 8'd1;
    chk("cb_ready_busy", 64'(bus.cmd_ready), 64'd0);
    step(); chk("cb_w1", 64'(bus.push_data), 64'h0_00000110);
    step(); chk("cb_w2", 64'(bus.push_data), 64'h1_00000120);
    step();
    chk("cb_done", 64'(done), 64'd1);
    chk("cb_ready_done", 64'(bus.cmd_ready), 64'd1);
    chk("cb_valid_gap", 64'(bus.push_valid), 64'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("cb_n0", 64'(bus.push_data), 64'h0_00000200);
    chk("cb_n0_valid", 64'(bus.push_valid), 64'd1);
    step(); chk("cb_n1", 64'(bus.push_data), 64'h1_00000202);
    step();
    chk("cb_n_done", 64'(done), 64'd1);
    chk("cb_words", 64'(words_sent), 64'd17);

    // Reset mid-burst after two of five words
    send_cmd(32'h300, 32'd1, 8'd4);
    step();
    step(); chk("rm_w2", 64'(bus.push_data), 64'h0_00000302);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rm_valid", 64'(bus.push_valid), 64'd0);
    chk("rm_data", 64'(bus.push_data), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_words", 64'(words_sent), 64'd0);
    chk("rm_stall", 64'(stall_cycles), 64'd0);
    chk("rm_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    chk("rm_idle_valid", 64'(bus.push_valid), 64'd0);
    send_cmd(32'h40, 32'd8, 8'd1);
    chk("rm_n0", 64'(bus.push_data), 64'h0_00000040);
    step(); chk("rm_n1", 64'(bus.push_data), 64'h1_00000048);
    step();
    chk("rm_done", 64'(done), 64'd1);
    chk("rm_words_after", 64'(words_sent), 64'd2);

    // Six-word burst into a depth-4 FIFO with pop stalled, then drained
    send_cmd(32'h1000, 32'd1, 8'd5);
    for (int i = 0; i < 10; i++) fifo_cycle();
    chk("ff_level", 64'(fifo_q.size()), 64'd4);
    chk("ff_stall_valid", 64'(bus.push_valid), 64'd1);
    chk("ff_stall_data", 64'(bus.push_data), 64'h0_00001004);
    pop_grant = 1'b1;
    for (int i = 0; i < 40 && popped.size() < 6; i++) fifo_cycle();
    chk("ff_drain_count", 64'(popped.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++) begin
      logic [32:0] exp_w;
      exp_w = {(i == 5), 32'h1000 + 32'(i)};
      chk("ff_word", 64'(popped[i]), 64'(exp_w));
    end
    chk("ff_words", 64'(words_sent), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
Push-side transmitter for the FIFO valid/grant interface. It accepts a burst command (start value, stride, length) and generates an arithmetic word sequence onto the FIFO push port. Bit DATA_WIDTH of each word carries the end-of-burst flag. It sits upstream of a FIFO instance as the traffic source for datapath streams and bench stimulus.

Parameters:
DATA_WIDTH, 32, payload width; the push word is DATA_WIDTH+1 bits, with the MSB as the last flag
LEN_WIDTH, 8, width of cmd_len_i; burst length = cmd_len_i+1 (1..2^LEN_WIDTH words)
CNT_WIDTH, 16, width of the status counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
cmd_valid_i  input  1  command offered
cmd_ready_o  output  1  command can be accepted (IDLE only)
cmd_start_i  input  DATA_WIDTH  first payload value
cmd_stride_i  input  DATA_WIDTH  increment between successive words
cmd_len_i  input  LEN_WIDTH  number of words minus one
push_data_o  output  DATA_WIDTH+1  word to FIFO: [DATA_WIDTH]=last, [DATA_WIDTH-1:0]=payload
push_valid_o  output  1  word offered to FIFO
push_grant_i  input  1  FIFO accepts the word this cycle
busy_o  output  1  burst in progress
done_o  output  1  one-cycle pulse after the final word transfers
words_sent_o  output  CNT_WIDTH  total transferred words since reset; wraps
stall_cycles_o  output  CNT_WIDTH  cycles with push_valid_o=1 and push_grant_i=0; saturates at all-ones

Behaviour:
- Reset is synchronous: rst_n=0 sampled on a clk edge forces state IDLE and the following output values:
  - push_valid_o=0, push_data_o=0, busy_o=0, done_o=0
  - words_sent_o=0, stall_cycles_o=0
  - cmd_ready_o=1 after the reset edge
  - Reset overrides all other events in the same cycle.
- Reset mid-burst abandons the burst immediately; no further words are offered, even if partially sent.
- Transfer rule: a transfer occurs on a clk edge where push_valid_o && push_grant_i.
- All outputs are registered. push_valid_o must not depend combinationally on push_grant_i.
- States: IDLE, SEND.
- IDLE:
  - cmd_ready_o=1, push_valid_o=0, busy_o=0.
  - On cmd_valid_i=1: latch stride and len, set remaining=cmd_len_i, load push_data_o={cmd_len_i==0, cmd_start_i}, and move to SEND.
  - Latency: command accepted at edge T, push_valid_o=1 from T onward (visible in cycle T+1).
- SEND:
  - cmd_ready_o=0, busy_o=1, push_valid_o=1. cmd_valid_i is ignored.
  - Without a transfer, push_data_o and push_valid_o are held stable. If stall_cycles_o is below max, it increments.
  - On a transfer with remaining>0: payload <= payload+stride (mod 2^DATA_WIDTH, carry discarded); remaining decrements; last bit <= (remaining==1).
  - On a transfer with remaining==0 (the last word):
    - push_valid_o<=0, push_data_o<=0, done_o<=1 for exactly one cycle, return to IDLE.
    - cmd_ready_o is 1 in that same cycle, so a new command can be accepted there.
- words_sent_o increments by 1 per transfer and wraps from all-ones to 0.
- Bursts are separated by at least one cycle with push_valid_o=0 (the IDLE acceptance cycle).
- The last flag is 1 on exactly one word per burst: the final one. A single-word burst (cmd_len_i=0) has last=1 on its only word.
- push_grant_i while push_valid_o=0 has no effect.
- Grant may be held high continuously; the block then sustains one word per cycle within a burst.

Test Plan:
- Basic burst (DATA_WIDTH=32): start=0x10, stride=4, len=3, grant tied 1.
  - Words 0x0_00000010, 0x0_00000014, 0x0_00000018, 0x1_0000001C on 4 consecutive cycles.
  - done_o pulses once in the next cycle; words_sent_o=4; stall_cycles_o=0.
- Backpressure: same command, grant=0 for 3 cycles while word 0x14 is offered.
  - 0x14 is held stable with valid=1 during the stall; stall_cycles_o=3.
  - Sequence and last flag are unchanged; no word is lost or duplicated.
- Wrap and single word:
  - start=0xFFFFFFFE, stride=1, len=2 -> 0x0_FFFFFFFE, 0x0_FFFFFFFF, 0x1_00000000.
  - Then start=0x5, len=0 -> one word 0x1_00000005, then done_o.
- Command while busy: cmd_valid_i pulsed mid-burst -> not accepted (cmd_ready_o=0). The burst completes unaltered; a command held through the done_o cycle is accepted and its first word appears in the next cycle.
- Reset mid-burst: rst_n=0 for one edge after 2 of 5 words.
  - All outputs return to reset values, including counters=0; push_valid_o=0.
  - The next command restarts cleanly from its own start value.
- With a FIFO of DEPTH=4 and pop_grant=0: a 6-word burst pushes 4 words, then stalls with valid=1. Releasing pop_grant drains all 6 in order, with last on word 6 only.
